plru_ctrl: RTL and testbench

Replacement-state controller for the set-associative data cache. Holds one tree-PLRU age vector per set and serialises hit-touch and miss-allocate requests from the cache controller against it. For a miss it returns the victim way; for any access it updates that set's tree. It also performs the post-reset/flush initialisation sweep of all age state.

---
 rtl/plru_ctrl_if.sv | 27 ++
 rtl/plru_ctrl.sv | 136 +++++++++++++
 tb/tb_plru_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plru_ctrl_if.sv
// Request/response bundle between the cache controller and the replacement-state controller.
// The master side issues hit-touch / miss-allocate requests; the slave side returns the chosen way.
interface plru_ctrl_if #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64
);
  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int SET_W = $clog2(NUM_SETS);

  logic             req_valid;
  logic             req_ready;
  logic [SET_W-1:0] req_set;
  logic             req_hit;
  logic [WAY_W-1:0] req_way;
  logic             rsp_valid;
  logic [WAY_W-1:0] rsp_way;

  modport master (
    output req_valid, req_set, req_hit, req_way,
    input  req_ready, rsp_valid, rsp_way
  );

  modport slave (
    input  req_valid, req_set, req_hit, req_way,
    output req_ready, rsp_valid, rsp_way
  );
endinterface

// File: rtl/plru_ctrl.sv
// Tree-PLRU replacement controller: one age vector per set, victim selection on miss,
// path update on every access, and a sweep that zeroes all age state after reset or flush.
module plru_ctrl #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 64
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       flush_i,
  plru_ctrl_if.slave bus,
  output logic       busy_o
);
  localparam int AGE_W  = NUM_WAYS - 1;
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int NODE_W = WAY_W + 1;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_e;

  state_e           state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WAY_W-1:0] rsp_way_q, rsp_way_d;

  logic [AGE_W-1:0] age_q [NUM_SETS];
  logic [AGE_W-1:0] age_rd;
  logic [AGE_W-1:0] age_upd;
  logic [AGE_W-1:0] wr_data;
  logic [SET_W-1:0] wr_set;
  logic             wr_en;
  logic             ready;
  logic             accept;

  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  acc_way;
  logic [NODE_W-1:0] vnode;
  logic [NODE_W-1:0] unode;
  logic              node_bit;

  assign age_rd = age_q[bus.req_set];

  // Victim walk follows the stored bits; the update then points every node on the
  // accessed way's path away from it. Node lookups use compares to stay width-exact.
  always_comb begin
    vnode    = '0;
    node_bit = 1'b0;
    for (int l = 0; l < WAY_W; l++) begin
      node_bit = 1'b0;
      for (int i = 0; i < AGE_W; i++) begin
        if (vnode == NODE_W'(i)) node_bit = age_rd[i];
      end
      vnode = {vnode[WAY_W-1:0], 1'b0} + NODE_W'(1) + NODE_W'(node_bit);
    end
    victim  = WAY_W'(vnode - NODE_W'(AGE_W));
    acc_way = bus.req_hit ? bus.req_way : victim;

    age_upd = age_rd;
    unode   = '0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int i = 0; i < AGE_W; i++) begin
        if (unode == NODE_W'(i)) age_upd[i] = ~acc_way[WAY_W-1-l];
      end
      unode = {unode[WAY_W-1:0], 1'b0} + NODE_W'(1) + NODE_W'(acc_way[WAY_W-1-l]);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_o      = 1'b0;
    ready       = 1'b0;
    wr_en       = 1'b0;
    wr_set      = bus.req_set;
    wr_data     = age_upd;
    accept      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_way_d   = rsp_way_q;

    case (state_q)
      ST_INIT: begin
        busy_o  = 1'b1;
        wr_en   = 1'b1;
        wr_set  = cnt_q;
        wr_data = '0;
        if (flush_i) begin
          cnt_d = '0;
        end else if (cnt_q == SET_W'(NUM_SETS - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SET_W'(1);
        end
      end
      ST_IDLE: begin
        ready = ~flush_i;
        if (flush_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (bus.req_valid) begin
          wr_en = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    accept      = ready & bus.req_valid;
    rsp_valid_d = accept;
    if (accept) rsp_way_d = acc_way;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_way_q   <= rsp_way_d;
    end
  end

  // Age array carries no reset; the init sweep is what gives it a known value.
  always_ff @(posedge clk_i) begin
    if (wr_en) age_q[wr_set] <= wr_data;
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_way   = rsp_way_q;
endmodule

// File: tb/tb_plru_ctrl.sv
// Scoreboard bench for plru_ctrl: directed scenarios plus random traffic checked against
// a per-set tree-PLRU model indexed by level and way prefix.
module tb_plru_ctrl;
  localparam int NUM_WAYS = 4;
  localparam int NUM_SETS = 4;
  localparam int WAY_W    = $clog2(NUM_WAYS);
  localparam int SET_W    = $clog2(NUM_SETS);
  localparam int AGE_W    = NUM_WAYS - 1;

  typedef struct {
    int    way;
    int    cyc;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  logic busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_way = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   model_tree [NUM_SETS][AGE_W];

  plru_ctrl_if #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) bus ();

  plru_ctrl #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .flush_i(flush),
    .bus    (bus.slave),
    .busy_o (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_clear();
    for (int s = 0; s < NUM_SETS; s++)
      for (int n = 0; n < AGE_W; n++) model_tree[s][n] = 0;
  endfunction

  // Level l of the tree holds 2^l nodes; the node visited is selected by the way prefix so far.
  function automatic int model_victim(input int s);
    int w = 0;
    for (int l = 0; l < WAY_W; l++) w = 2 * w + model_tree[s][(1 << l) - 1 + w];
    return w;
  endfunction

  function automatic void model_update(input int s, input int w);
    for (int l = 0; l < WAY_W; l++)
      model_tree[s][(1 << l) - 1 + (w >> (WAY_W - l))] = ((w >> (WAY_W - 1 - l)) & 1) ? 0 : 1;
  endfunction

  // Monitor: every response pops one expectation; idle cycles must hold the last way.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_rsp: got way %0d expected no response", bus.rsp_way);
        end else begin
          mon_e = exp_q.pop_front();
          check_output(mon_e.name, int'(bus.rsp_way), mon_e.way);
          check_output({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
          last_way = mon_e.way;
        end
      end else begin
        check_output("rsp_way_hold", int'(bus.rsp_way), last_way);
      end
    end
  end

  // Called at posedge+1; holds the request until ready, then books the expected response.
  task automatic apply_stimulus(input int s, input int hit, input int way, input int exp_way,
                                input string name);
    bit   accepted = 0;
    int   acc;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_set   = SET_W'(s);
    bus.req_hit   = hit[0];
    bus.req_way   = WAY_W'(way);
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        accepted = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_accept: got no ready expected ready within 200 cycles", name);
      bus.req_valid = 1'b0;
      return;
    end
    acc    = hit ? way : model_victim(s);
    e.way  = (exp_way >= 0) ? exp_way : acc;
    e.cyc  = cyc + 1;
    e.name = name;
    exp_q.push_back(e);
    model_update(s, acc);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_flush(input int with_valid, input int s, input int check_busy);
    flush = 1'b1;
    if (with_valid != 0) begin
      bus.req_valid = 1'b1;
      bus.req_hit   = 1'b0;
      bus.req_set   = SET_W'(s);
    end
    @(negedge clk);
    check_output("flush_ready_low", int'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    model_clear();
    if (check_busy != 0) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_output($sformatf("flush_busy_%0d", k), int'(busy), 1);
      end
      @(negedge clk);
      check_output("flush_busy_done", int'(busy), 0);
      check_output("flush_ready_up", int'(bus.req_ready), 1);
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset at the current time; any booked response is discarded with it.
  task automatic reset_dut();
    bit done = 0;
    rstn = 1'b0;
    #1;
    exp_q.delete();
    last_way = 0;
    model_clear();
    check_output("rst_rsp_valid", int'(bus.rsp_valid), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL init_done: got busy expected idle within 100 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   s;
    int   hit;
    int   way;
    rstn          = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_set   = '0;
    bus.req_hit   = 1'b0;
    bus.req_way   = '0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", int'(busy), 1);
    check_output("rst_ready", int'(bus.req_ready), 0);
    check_output("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check_output("rst_rsp_way", int'(bus.rsp_way), 0);

    // Request held valid through the whole sweep must wait for ready.
    bus.req_valid = 1'b1;
    bus.req_set   = '0;
    bus.req_hit   = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_output($sformatf("init_busy_%0d", k), int'(busy), 1);
      check_output($sformatf("init_ready_%0d", k), int'(bus.req_ready), 0);
      @(negedge clk);
    end
    check_output("init_busy_done", int'(busy), 0);
    check_output("init_ready_up", int'(bus.req_ready), 1);
    e.way  = 0;
    e.cyc  = cyc + 1;
    e.name = "init_first_miss";
    exp_q.push_back(e);
    model_update(0, 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    reset_dut();
    apply_stimulus(0, 0, 0, 0, "b2b_miss0");
    apply_stimulus(0, 0, 0, 2, "b2b_miss1");
    apply_stimulus(0, 0, 0, 1, "b2b_miss2");
    apply_stimulus(0, 0, 0, 3, "b2b_miss3");
    apply_stimulus(0, 0, 0, 0, "b2b_miss4");
    repeat (2) @(posedge clk);
    #1;

    reset_dut();
    apply_stimulus(0, 1, 0, 0, "hit_way0");
    apply_stimulus(0, 1, 2, 2, "hit_way2");
    apply_stimulus(0, 0, 0, 1, "miss_after_hits");
    repeat (2) @(posedge clk);
    #1;

    reset_dut();
    apply_stimulus(0, 0, 0, 0, "iso_set0_a");
    apply_stimulus(0, 0, 0, 2, "iso_set0_b");
    apply_stimulus(1, 0, 0, 0, "iso_set1");
    apply_stimulus(0, 0, 0, 1, "iso_set0_c");
    repeat (2) @(posedge clk);
    #1;

    reset_dut();
    apply_stimulus(2, 0, 0, 0, "fl_set2_a");
    apply_stimulus(2, 0, 0, 2, "fl_set2_b");
    apply_stimulus(2, 0, 0, 1, "fl_set2_c");
    do_flush(1, 2, 1);
    apply_stimulus(2, 0, 0, 0, "fl_retry_set2");
    repeat (2) @(posedge clk);
    #1;

    // A flush during the sweep restarts it from set 0.
    do_flush(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_flush(0, 0, 1);

    apply_stimulus(3, 0, 0, 0, "pre_rst_miss");
    check_output("pre_rst_rsp_valid", int'(bus.rsp_valid), 1);
    reset_dut();
    for (int i = 0; i < NUM_SETS; i++) apply_stimulus(i, 0, 0, 0, $sformatf("post_rst_set%0d", i));
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      s   = $urandom_range(0, NUM_SETS - 1);
      hit = $urandom_range(0, 1);
      way = $urandom_range(0, NUM_WAYS - 1);
      if ($urandom_range(0, 39) == 0) do_flush($urandom_range(0, 1), s, 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      apply_stimulus(s, hit, way, -1, hit ? "rand_hit" : "rand_miss");
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("drain_pending", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
